// File: rtl/dmem_lsu_pkg.sv
// Shared types and load-path helpers for the data-memory load/store sequencer.
package dmem_lsu_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    RESP  = 2'd2
  } lsu_state_e;

  // Illegal size or an address not aligned to the access size.
  function automatic logic access_err(input lsu_size_e size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = (addr_lo != 2'd0);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Index of the last byte of a store (N-1).
  function automatic logic [1:0] last_idx(input lsu_size_e size);
    logic [1:0] idx;
    case (size)
      SZ_BYTE: idx = 2'd0;
      SZ_HALF: idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Pick the addressed lane out of a memory word and sign/zero extend it.
  function automatic logic [DATA_WIDTH-1:0] lane_extract(
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [1:0]            addr_lo,
    input lsu_size_e             size,
    input logic                  is_unsigned
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] res;
    b = rdata[8*addr_lo +: 8];
    h = rdata[16*addr_lo[1] +: 16];
    case (size)
      SZ_BYTE: res = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_lsu_seq.sv
// Load/store sequencer: aligned loads with lane extraction, stores serialised
// into one-hot byte writes, one response per accepted request.
module dmem_lsu_seq
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned DMEM_SZ_IN_KB = 1,
  localparam int unsigned ADDR_WIDTH = $clog2(DMEM_SZ_IN_KB * 1024)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_write_en,
  output logic [3:0]            mem_mask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e            state_q, state_d;
  logic [1:0]            k_q, k_d;
  logic [1:0]            last_q, last_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rdy_q, rdy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  wr_en_q, wr_en_d;
  logic [3:0]            wr_mask_q, wr_mask_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  lsu_size_e             size;
  logic                  req_err;
  logic [1:0]            nxt_k;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [7:0]            nxt_byte;

  // State and output registers; reset aborts any store in flight.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      last_q      <= 2'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      rdy_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_mask_q   <= 4'd0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      last_q      <= last_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rdy_q       <= rdy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_en_q     <= wr_en_d;
      wr_mask_q   <= wr_mask_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Next state, response capture and the byte write to present next cycle.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    last_d      = last_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wr_en_d     = 1'b0;
    wr_mask_d   = 4'd0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    size        = lsu_size_e'(req_size);
    req_err     = access_err(size, req_addr[1:0]);
    nxt_k       = 2'd0;
    nxt_addr    = req_addr;
    nxt_byte    = req_wdata[7:0];

    case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (!req_we) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = lane_extract(mem_rdata, req_addr[1:0], size, req_unsigned);
          end else begin
            state_d = STORE;
            k_d     = 2'd0;
            last_d  = last_idx(size);
            base_d  = req_addr;
            wdata_d = req_wdata;
            wr_en_d = 1'b1;
          end
        end
      end
      STORE: begin
        if (k_q == last_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          nxt_k    = k_q + 2'd1;
          k_d      = nxt_k;
          nxt_addr = base_q + ADDR_WIDTH'(nxt_k);
          nxt_byte = wdata_q[8*nxt_k +: 8];
          wr_en_d  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en_d) begin
      wr_addr_d = nxt_addr;
      wr_mask_d = 4'b0001 << nxt_addr[1:0];
      wr_data_d = DATA_WIDTH'(nxt_byte) << {nxt_addr[1:0], 3'b000};
    end

    rdy_d = (state_d == IDLE);
  end

  // Loads address memory straight from the request while idle.
  assign mem_addr     = (state_q == STORE) ? wr_addr_q : (rdy_q ? req_addr : '0);
  assign req_ready    = rdy_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign mem_write_en = wr_en_q;
  assign mem_mask     = wr_mask_q;
  assign mem_wdata    = wr_data_q;

endmodule

// File: tb/tb_dmem_lsu_seq.sv
// Bench for dmem_lsu_seq: byte-array data memory, byte-level reference model.
module tb_dmem_lsu_seq;

  localparam int unsigned AW    = 10;
  localparam int unsigned MEM_B = 1024;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_write_en;
  logic [3:0]    mem_mask;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] dmem    [MEM_B];
  logic [7:0] ref_mem [MEM_B];

  always #5 clk = ~clk;

  dmem_lsu_seq #(.DMEM_SZ_IN_KB(1)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_write_en(mem_write_en), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, masked write, cleared by reset.
  assign mem_rdata = {dmem[{mem_addr[AW-1:2], 2'd3}], dmem[{mem_addr[AW-1:2], 2'd2}],
                      dmem[{mem_addr[AW-1:2], 2'd1}], dmem[{mem_addr[AW-1:2], 2'd0}]};

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < MEM_B; i++) dmem[i] <= 8'd0;
    end else if (mem_write_en) begin
      for (int l = 0; l < 4; l++)
        if (mem_mask[l]) dmem[{mem_addr[AW-1:2], 2'(l)}] <= mem_wdata[8*l +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request end to end, expectations from the byte-level model.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wdata, input int hold);
    logic        err;
    int          nb, nw, waited, a;
    logic [31:0] exp_rd;
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    nw  = (!err && we) ? nb : 0;
    exp_rd = 32'd0;
    if (!err && !we) begin
      for (int i = 0; i < nb; i++) exp_rd |= 32'(ref_mem[(int'(addr) + i) % MEM_B]) << (8 * i);
      if (!uns && size == 2'd0 && exp_rd[7])  exp_rd |= 32'hFFFF_FF00;
      if (!uns && size == 2'd1 && exp_rd[15]) exp_rd |= 32'hFFFF_0000;
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1) == 1; req_size = 2'($urandom);
    req_addr = AW'($urandom); req_wdata = $urandom;

    for (int c = 0; c < nw; c++) begin
      a = (int'(addr) + c) % MEM_B;
      @(negedge clk);
      chk("wr_en",    32'(mem_write_en), 32'd1);
      chk("wr_mask",  32'(mem_mask),     32'(4'b0001 << (a % 4)));
      chk("wr_addr",  32'(mem_addr),     32'(a));
      chk("wr_data",  mem_wdata,         32'(wdata[8*c +: 8]) << (8 * (a % 4)));
      chk("wr_rspv",  32'(rsp_valid),    32'd0);
      ref_mem[a] = wdata[8*c +: 8];
    end

    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid),    32'd1);
    chk("rsp_rdata", rsp_rdata,         exp_rd);
    chk("rsp_err",   32'(rsp_err),      32'(err));
    chk("rsp_wr_en", 32'(mem_write_en), 32'd0);
    chk("rsp_busy",  32'(req_ready),    32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata,      exp_rd);
      chk("hold_err",   32'(rsp_err),   32'(err));
      chk("hold_busy",  32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    sz;
    logic [AW-1:0] ad;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = AW'(10'h155); req_wdata = 32'd0; rsp_ready = 1'b0;
    for (int i = 0; i < MEM_B; i++) ref_mem[i] = 8'd0;

    #12;
    chk("rst_req_ready", 32'(req_ready),    32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid),    32'd0);
    chk("rst_rsp_rdata", rsp_rdata,         32'd0);
    chk("rst_rsp_err",   32'(rsp_err),      32'd0);
    chk("rst_wr_en",     32'(mem_write_en), 32'd0);
    chk("rst_mask",      32'(mem_mask),     32'd0);
    chk("rst_addr",      32'(mem_addr),     32'd0);
    chk("rst_wdata",     mem_wdata,         32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Word store / load round trip.
    run_req(1'b1, 2'd2, 1'b0, AW'(10'h10), 32'hDEAD_BEEF, 0);
    run_req(1'b0, 2'd2, 1'b0, AW'(10'h10), 32'd0, 0);
    // Half store, signed/unsigned half and signed byte loads.
    run_req(1'b1, 2'd1, 1'b0, AW'(10'h22), 32'h0000_8001, 0);
    run_req(1'b0, 2'd1, 1'b0, AW'(10'h22), 32'd0, 0);
    run_req(1'b0, 2'd1, 1'b1, AW'(10'h22), 32'd0, 0);
    run_req(1'b0, 2'd0, 1'b0, AW'(10'h23), 32'd0, 0);
    // Misaligned and illegal accesses, then confirm memory untouched.
    run_req(1'b1, 2'd2, 1'b0, AW'(10'h11), 32'h1111_1111, 0);
    run_req(1'b1, 2'd1, 1'b0, AW'(10'h13), 32'h2222_2222, 0);
    run_req(1'b1, 2'd3, 1'b0, AW'(10'h00), 32'h3333_3333, 0);
    run_req(1'b0, 2'd2, 1'b0, AW'(10'h10), 32'd0, 0);
    // Back-pressure on a load response.
    run_req(1'b0, 2'd2, 1'b0, AW'(10'h10), 32'd0, 5);
    // Single byte store into the top lane.
    run_req(1'b1, 2'd0, 1'b0, AW'(10'h03), 32'h0000_00A5, 0);
    run_req(1'b0, 2'd2, 1'b1, AW'(10'h00), 32'd0, 0);

    // Reset while the second byte of a word store is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = AW'(10'h30); req_wdata = 32'h1234_5678;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_b0_mask", 32'(mem_mask), 32'd1);
    @(negedge clk);
    chk("mid_b1_mask", 32'(mem_mask), 32'd2);
    #1;
    arst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(mem_write_en), 32'd0);
    chk("mid_rst_mask",  32'(mem_mask),     32'd0);
    chk("mid_rst_addr",  32'(mem_addr),     32'd0);
    chk("mid_rst_wdata", mem_wdata,         32'd0);
    chk("mid_rst_rdy",   32'(req_ready),    32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_quiet", 32'(mem_write_en), 32'd0);
    end
    arst_n = 1'b1;
    for (int i = 0; i < MEM_B; i++) ref_mem[i] = 8'd0;
    repeat (2) @(negedge clk);
    chk("mid_rst_after_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_after_wr",    32'(mem_write_en), 32'd0);
    run_req(1'b0, 2'd2, 1'b0, AW'(10'h30), 32'd0, 0);

    // Random mix over a small window to force overlaps.
    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      ad = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'd0;
      end
      run_req($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, ad, $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
